turn_sequencer: RTL and testbench

//  Parametrised turn controller for the board game. Counts accepted picks (select on an empty cell) per turn.
//  At end of turn, samples the pair-compare result, updates the per-player score and passes or keeps the turn.

---
 rtl/turn_sequencer.sv | 150 +++++++++++++++
 tb/tb_turn_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/turn_sequencer.sv
// Turn controller for the board game: counts accepted picks per turn, scores matches,
// rotates players and forces a pass after an optional inactivity timeout.
module turn_sequencer #(
    parameter int NUM_PLAYERS    = 2,
    parameter int PICKS_PER_TURN = 2,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int SCORE_W        = 8,
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int CW = $clog2(PICKS_PER_TURN + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           select,
    input  logic                           empty,
    input  logic                           match,
    output logic [PW-1:0]                  player,
    output logic [CW-1:0]                  pick_cnt,
    output logic                           busy,
    output logic                           turn_done,
    output logic [1:0]                     x,
    output logic [NUM_PLAYERS*SCORE_W-1:0] score
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CW-1:0] PICK_LAST  = CW'(PICKS_PER_TURN - 1);
    localparam logic [PW-1:0] PLAYER_LAST = PW'(NUM_PLAYERS - 1);

    localparam logic [1:0] X_NONE    = 2'b00;
    localparam logic [1:0] X_PASS    = 2'b01;
    localparam logic [1:0] X_MATCH   = 2'b10;
    localparam logic [1:0] X_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        EVAL = 2'd2
    } state_t;

    state_t               state_reg,     state_next;
    logic [PW-1:0]        player_reg,    player_next;
    logic [CW-1:0]        pick_cnt_reg,  pick_cnt_next;
    logic [TW-1:0]        timer_reg,     timer_next;
    logic                 turn_done_reg, turn_done_next;
    logic [1:0]           x_reg,         x_next;
    logic [SCORE_W-1:0]   score_reg  [NUM_PLAYERS];
    logic [SCORE_W-1:0]   score_next [NUM_PLAYERS];
    logic [PW-1:0]        player_adv;

    assign player_adv = (player_reg == PLAYER_LAST) ? '0 : player_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            player_reg    <= '0;
            pick_cnt_reg  <= '0;
            timer_reg     <= '0;
            turn_done_reg <= 1'b0;
            x_reg         <= X_NONE;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_reg[i] <= '0;
            end
        end else begin
            state_reg     <= state_next;
            player_reg    <= player_next;
            pick_cnt_reg  <= pick_cnt_next;
            timer_reg     <= timer_next;
            turn_done_reg <= turn_done_next;
            x_reg         <= x_next;
            score_reg     <= score_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        player_next    = player_reg;
        pick_cnt_next  = pick_cnt_reg;
        timer_next     = timer_reg;
        turn_done_next = 1'b0;
        x_next         = x_reg;
        score_next     = score_reg;

        if (start) begin
            state_next    = PICK;
            player_next   = '0;
            pick_cnt_next = '0;
            timer_next    = '0;
            x_next        = X_NONE;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_next[i] = '0;
            end
        end else begin
            case (state_reg)
                PICK: begin
                    if (select && empty) begin
                        timer_next = '0;
                        if (pick_cnt_reg == PICK_LAST) begin
                            pick_cnt_next = '0;
                            state_next    = EVAL;
                        end else begin
                            pick_cnt_next = pick_cnt_reg + 1'b1;
                        end
                    end else if (TIMEOUT_CYCLES > 0) begin
                        // Rejected picks (select on a full cell) still count as inactivity.
                        if (timer_reg == TIMER_LAST) begin
                            x_next         = X_TIMEOUT;
                            turn_done_next = 1'b1;
                            player_next    = player_adv;
                            pick_cnt_next  = '0;
                            timer_next     = '0;
                        end else begin
                            timer_next = timer_reg + 1'b1;
                        end
                    end
                end
                EVAL: begin
                    state_next     = PICK;
                    timer_next     = '0;
                    turn_done_next = 1'b1;
                    if (match) begin
                        x_next = X_MATCH;
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (PW'(i) == player_reg && score_reg[i] != '1) begin
                                score_next[i] = score_reg[i] + 1'b1;
                            end
                        end
                    end else begin
                        x_next      = X_PASS;
                        player_next = player_adv;
                    end
                end
                default: ;
            endcase
        end
    end

    assign player    = player_reg;
    assign pick_cnt  = pick_cnt_reg;
    assign busy      = (state_reg != IDLE);
    assign turn_done = turn_done_reg;
    assign x         = x_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score
            assign score[gi*SCORE_W +: SCORE_W] = score_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_turn_sequencer.sv
// Randomized bench for turn_sequencer: a turn-level reference model predicts every
// registered output each cycle; one line is printed per completed turn.
module tb_turn_sequencer;
    localparam int NP   = 3;
    localparam int PPT  = 2;
    localparam int TO   = 5;
    localparam int SW   = 4;
    localparam int PW   = (NP > 2) ? $clog2(NP) : 1;
    localparam int CW   = $clog2(PPT + 1);
    localparam int SMAX = (1 << SW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              select = 1'b0;
    logic              empty = 1'b0;
    logic              match = 1'b0;
    logic [PW-1:0]     player;
    logic [CW-1:0]     pick_cnt;
    logic              busy;
    logic              turn_done;
    logic [1:0]        x;
    logic [NP*SW-1:0]  score;

    int checks = 0;
    int failures = 0;

    // Reference model: game-level view of the turn.
    bit m_playing;      // a game is in progress
    bit m_judging;      // all picks made, waiting for the match verdict
    int m_player, m_picks, m_quiet, m_x, m_turns;
    bit m_done;
    int m_score [NP];

    turn_sequencer #(
        .NUM_PLAYERS(NP), .PICKS_PER_TURN(PPT), .TIMEOUT_CYCLES(TO), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .select(select), .empty(empty), .match(match),
        .player(player), .pick_cnt(pick_cnt), .busy(busy), .turn_done(turn_done),
        .x(x), .score(score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_playing = 0; m_judging = 0;
        m_player = 0; m_picks = 0; m_quiet = 0; m_x = 0; m_done = 0;
        foreach (m_score[i]) m_score[i] = 0;
    endfunction

    function automatic void finish_turn(input int outcome, input bit pass_turn);
        m_done = 1;
        m_x = outcome;
        m_turns++;
        $display("turn %0d: player %0d outcome %0d score %0d", m_turns, m_player, outcome, m_score[m_player]);
        if (pass_turn) m_player = (m_player + 1) % NP;
    endfunction

    function automatic void model_step();
        if (!rst) begin
            model_reset();
        end else if (start) begin
            model_reset();
            m_playing = 1;
        end else begin
            m_done = 0;
            if (m_playing && m_judging) begin
                m_judging = 0;
                m_quiet = 0;
                if (match) begin
                    if (m_score[m_player] < SMAX) m_score[m_player]++;
                    finish_turn(2, 0);
                end else begin
                    finish_turn(1, 1);
                end
            end else if (m_playing) begin
                if (select && empty) begin
                    m_quiet = 0;
                    m_picks++;
                    if (m_picks == PPT) begin
                        m_picks = 0;
                        m_judging = 1;
                    end
                end else begin
                    m_quiet++;
                    if (m_quiet == TO) begin
                        m_picks = 0;
                        m_quiet = 0;
                        finish_turn(3, 1);
                    end
                end
            end
        end
    endfunction

    task automatic step_and_check();
        @(posedge clk);
        model_step();
        #1;
        check("player", player, m_player);
        check("pick_cnt", pick_cnt, m_picks);
        check("busy", busy, m_playing);
        check("turn_done", turn_done, m_done);
        check("x", x, m_x);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("score%0d", i), score[i*SW +: SW], m_score[i]);
        end
    endtask

    initial begin
        m_turns = 0;
        model_reset();
        // Reset held low for two edges, then released with no start: stays idle.
        rst = 1'b0;
        step_and_check();
        step_and_check();
        rst = 1'b1;
        step_and_check();
        step_and_check();
        start = 1'b1;
        step_and_check();
        start = 1'b0;

        for (int n = 0; n < 6000; n++) begin
            bit lazy;
            // Alternate busy and sluggish stretches so both full turns and timeouts occur.
            lazy   = ((n / 400) % 2) == 1;
            rst    = ($urandom_range(0, 399) != 0);
            start  = ($urandom_range(0, 199) == 0);
            select = lazy ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 9) < 7);
            empty  = ($urandom_range(0, 3) != 0);
            match  = ($urandom_range(0, 2) != 0);
            step_and_check();
            if (!busy && rst && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                step_and_check();
                start = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
